// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared fetch-state encoding, IR byte-select codes and the reset PC.
// Latency: none; this package holds only types and constants.
// Backpressure: none; the package contains no logic.
package instruction_fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH_LO = 2'd1,
      FETCH_HI = 2'd2,
      DONE     = 2'd3
   } fetch_state_t;

   localparam logic        IR_LH_LOW      = 1'b0;
   localparam logic        IR_LH_HIGH     = 1'b1;
   localparam logic [15:0] PC_RESET_VALUE = 16'h0000;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Bundles the control, memory and IR load signals of the fetch sequencer.
// Latency: none; the interface is wiring only.
// Backpressure: memory stalls a byte through MemReady; control waits on Done.
interface instruction_fetch_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              Start;
   logic              PCLoad;
   logic [ADDR_W-1:0] PCIn;
   logic [DATA_W-1:0] MemData;
   logic              MemReady;
   logic              MemRead;
   logic [ADDR_W-1:0] MemAddr;
   logic              IRWrite;
   logic              IRLH;
   logic [DATA_W-1:0] IRData;
   logic [ADDR_W-1:0] PCOut;
   logic              Busy;
   logic              Done;

   // The sequencer side.
   modport master (
      input  Start, PCLoad, PCIn, MemData, MemReady,
      output MemRead, MemAddr, IRWrite, IRLH, IRData, PCOut, Busy, Done
   );

   // The control unit, memory and IR side.
   modport slave (
      output Start, PCLoad, PCIn, MemData, MemReady,
      input  MemRead, MemAddr, IRWrite, IRLH, IRData, PCOut, Busy, Done
   );
endinterface

// File: rtl/instruction_fetch_sequencer_program_counter.sv
// Program counter register with a parallel load and an increment by one.
// Latency: a load or an increment becomes visible on pc one cycle later.
// Backpressure: none; the counter holds its value when neither load nor inc is set.
module program_counter #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // Load wins over increment; the increment wraps modulo 2^ADDR_W.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         pc <= PC_RESET;
      end else if (load) begin
         pc <= load_value;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetches one 16-bit instruction as two bytes (low byte, then high byte) into the IR.
// Latency: the IR bytes are written on the edges after Start; Done follows one cycle later.
// Backpressure: each byte holds in its state until MemReady; Start is ignored while busy.
module instruction_fetch_sequencer
   import instruction_fetch_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_VALUE)
) (
   input logic                          Clock,
   input logic                          Reset,
   instruction_fetch_sequencer_if.master bus
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] pc;

   program_counter #(
      .ADDR_W   (ADDR_W),
      .PC_RESET (PC_RESET)
   ) u_program_counter (
      .Clock      (Clock),
      .Reset      (Reset),
      .load       (pc_load),
      .load_value (bus.PCIn),
      .inc        (pc_inc),
      .pc         (pc)
   );

   // State register; reset abandons any fetch in flight.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, PC control and state-decoded outputs.
   always_comb begin
      state_nxt   = state;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      bus.MemRead = 1'b0;
      bus.IRWrite = 1'b0;
      bus.IRLH    = IR_LH_LOW;
      bus.Busy    = 1'b0;
      bus.Done    = 1'b0;
      case (state)
         IDLE: begin
            // A jump and a start in the same cycle fetch from the new PC.
            pc_load = bus.PCLoad;
            if (bus.Start) begin
               state_nxt = FETCH_LO;
            end
         end
         FETCH_LO: begin
            bus.Busy    = 1'b1;
            bus.MemRead = 1'b1;
            bus.IRWrite = bus.MemReady;
            pc_inc      = bus.MemReady;
            if (bus.MemReady) begin
               state_nxt = FETCH_HI;
            end
         end
         FETCH_HI: begin
            bus.Busy    = 1'b1;
            bus.MemRead = 1'b1;
            bus.IRLH    = IR_LH_HIGH;
            bus.IRWrite = bus.MemReady;
            pc_inc      = bus.MemReady;
            if (bus.MemReady) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.Done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The address always shows PC; IR data is held at zero outside a read.
   assign bus.MemAddr = pc;
   assign bus.PCOut   = pc;
   assign bus.IRData  = bus.MemRead ? bus.MemData : '0;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Randomized and directed bench for instruction_fetch_sequencer against a transaction model.
// Latency: checks the byte writes and Done cycle by cycle, sampled on the falling edge.
// Backpressure: drives MemReady stalls and ignored Start/PCLoad during a fetch.
module tb_instruction_fetch_sequencer;
   import instruction_fetch_sequencer_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;

   logic Clock = 1'b0;
   logic Reset;

   always #5 Clock = ~Clock;

   instruction_fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   instruction_fetch_sequencer #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [7:0] mem [0:65535];
   assign bus.MemData = mem[bus.MemAddr];

   int n_chk = 0;
   int n_bad = 0;

   // Transaction-level model: PC, bytes still owed by the current fetch, Done due.
   int          m_pc;
   int          m_left;
   bit          m_done;
   int          m_start;
   logic [15:0] ir;
   int          cyc = 0;
   int          done_count = 0;
   int          last_done_cyc = 0;
   bit          chk_period = 0;
   bit          period_armed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: compare outputs against the model, then commit the edge.
   task automatic tick();
      @(negedge Clock);
      cyc++;
      check("busy",    {31'd0, bus.Busy},    {31'd0, m_left > 0});
      check("memread", {31'd0, bus.MemRead}, {31'd0, m_left > 0});
      check("done",    {31'd0, bus.Done},    {31'd0, m_done});
      check("irwrite", {31'd0, bus.IRWrite}, {31'd0, (m_left > 0) && bus.MemReady});
      check("memaddr", {16'd0, bus.MemAddr}, m_pc);
      check("pcout",   {16'd0, bus.PCOut},   m_pc);
      if (m_left > 0) begin
         check("irlh", {31'd0, bus.IRLH}, {31'd0, m_left == 1});
      end
      if (bus.IRWrite) begin
         check("irdata", {24'd0, bus.IRData}, {24'd0, mem[m_pc]});
         if (bus.IRLH) ir[15:8] = bus.IRData;
         else          ir[7:0]  = bus.IRData;
      end
      if (bus.Done) begin
         done_count++;
         check("ir_word", {16'd0, ir}, {16'd0, mem[(m_start + 1) % 65536], mem[m_start]});
         if (chk_period && period_armed) begin
            check("done_period", cyc - last_done_cyc, 4);
         end
         period_armed  = 1'b1;
         last_done_cyc = cyc;
      end
      if (!Reset) begin
         m_pc   = 0;
         m_left = 0;
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (bus.MemReady) begin
            m_pc   = (m_pc + 1) % 65536;
            m_left = m_left - 1;
            m_done = (m_left == 0);
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else begin
         if (bus.PCLoad) m_pc = int'(bus.PCIn);
         if (bus.Start) begin
            m_left  = 2;
            m_start = m_pc;
         end
      end
      @(posedge Clock);
      #1;
   endtask

   initial begin
      int d0;
      int p0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0040] = 8'h34;
      mem[16'h0041] = 8'h12;
      ir           = '0;
      bus.Start    = 1'b0;
      bus.PCLoad   = 1'b0;
      bus.PCIn     = '0;
      bus.MemReady = 1'b0;
      Reset        = 1'b0;
      @(posedge Clock);
      #1;
      m_pc   = 0;
      m_left = 0;
      m_done = 1'b0;
      Reset  = 1'b1;
      tick();

      // Jump and start together, memory always ready.
      bus.PCLoad = 1'b1; bus.PCIn = 16'h0040; bus.Start = 1'b1; bus.MemReady = 1'b1;
      tick();
      bus.PCLoad = 1'b0; bus.Start = 1'b0;
      repeat (3) tick();
      check("t1_pc", {16'd0, bus.PCOut}, 32'h0042);
      check("t1_ir", {16'd0, ir}, 32'h1234);

      // Memory stalls: 3 cycles on the low byte, 2 on the high byte.
      bus.MemReady = 1'b0; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (3) tick();
      bus.MemReady = 1'b1; tick();
      bus.MemReady = 1'b0; repeat (2) tick();
      bus.MemReady = 1'b1; tick();
      tick();
      check("t2_pc", {16'd0, bus.PCOut}, 32'h0044);

      // Fetch straddling the address wrap.
      bus.PCLoad = 1'b1; bus.PCIn = 16'hFFFF;
      tick();
      bus.PCLoad = 1'b0; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (3) tick();
      check("t3_pc", {16'd0, bus.PCOut}, 32'h0001);

      // Start and PCLoad during FETCH_HI and DONE are ignored.
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      bus.Start = 1'b1; bus.PCLoad = 1'b1; bus.PCIn = 16'h0100;
      repeat (2) tick();
      bus.Start = 1'b0; bus.PCLoad = 1'b0;
      tick();
      check("t4_pc", {16'd0, bus.PCOut}, 32'h0003);
      check("t4_idle", {31'd0, bus.Busy}, 32'd0);

      // Reset in FETCH_HI while memory is stalled.
      bus.MemReady = 1'b0; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0; bus.MemReady = 1'b1;
      tick();
      bus.MemReady = 1'b0; Reset = 1'b0;
      tick();
      Reset = 1'b1;
      check("t5_pc", {16'd0, bus.PCOut}, 32'h0000);
      check("t5_outs", {28'd0, bus.MemRead, bus.IRWrite, bus.Busy, bus.Done}, 32'd0);
      bus.Start = 1'b1; bus.MemReady = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (3) tick();
      check("t5_refetch_pc", {16'd0, bus.PCOut}, 32'h0002);

      // Continuous Start with memory ready: one fetch every 4 cycles.
      d0 = done_count; p0 = m_pc;
      chk_period = 1'b1; period_armed = 1'b0;
      bus.Start = 1'b1; bus.MemReady = 1'b1;
      repeat (16) tick();
      check("t6_dones", done_count - d0, 4);
      check("t6_pc", {16'd0, bus.PCOut}, (p0 + 8) % 65536);
      bus.Start = 1'b0; chk_period = 1'b0;
      repeat (4) tick();

      // Random traffic, including occasional resets.
      d0 = done_count;
      for (int i = 0; i < 3000; i++) begin
         bus.Start    = ($urandom_range(0, 1) == 1);
         bus.PCLoad   = ($urandom_range(0, 3) == 0);
         bus.PCIn     = 16'($urandom);
         bus.MemReady = ($urandom_range(0, 4) < 3);
         Reset        = ($urandom_range(0, 63) != 0);
         tick();
      end
      Reset = 1'b1; bus.Start = 1'b0; bus.PCLoad = 1'b0; bus.MemReady = 1'b1;
      repeat (4) tick();
      check("rand_progress", {31'd0, done_count - d0 > 100}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
